// File: rtl/maq_relogio_pkg.sv
// Shared clock-stage definitions: FSM state encoding, BCD hour limits and a
// BCD-to-binary helper used by the display decoder.
package maq_relogio_pkg;

  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    AJUSTE = 1'b1
  } estado_t;

  localparam logic [1:0] HORA_MSD_MAX    = 2'd2;
  localparam logic [3:0] HORA_LSD_MAX_23 = 4'd3;
  localparam logic [3:0] LSD_MAX         = 4'd9;

  function automatic logic [4:0] bcd_para_bin(input logic [1:0] msd, input logic [3:0] lsd);
    return ({3'b000, msd} * 5'd10) + {1'b0, lsd};
  endfunction

endpackage

// File: rtl/maq_h_detector_borda.sv
// Rising-edge detector for one debounced, synchronised button.
module maq_h_detector_borda (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sinal,
  output logic o_borda
);

  logic r_anterior;

  // NOTE: reset is synchronous here, so it lives inside the clocked branch
  // rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) r_anterior <= 1'b0;
    else        r_anterior <= i_sinal;
  end

  assign o_borda = i_sinal & ~r_anterior;

endmodule

// File: rtl/maq_h.sv
// Hours stage of a digital clock: 24 h BCD counter with manual set mode.
// Define MAQ_H_FORMATO_12H_EN to decode the display as 12 h with a PM flag.
module maq_h
  import maq_relogio_pkg::*;
(
  input  logic       maq_h_clock,
  input  logic       maq_h_reset,
  input  logic       maq_h_enable1hz,
  input  logic       maq_h_incremento_hora,
  input  logic       maq_h_ajuste,
  input  logic       maq_h_botao_inc,
  input  logic       maq_h_botao_dec,
  output logic [3:0] maq_h_bcd_h_lsd,
  output logic [1:0] maq_h_bcd_h_msd,
  output logic [3:0] maq_h_disp_lsd,
  output logic [1:0] maq_h_disp_msd,
  output logic       maq_h_pm,
  output logic       maq_h_incremento_dia
);

  estado_t    r_estado;
  logic [1:0] r_msd;
  logic [3:0] r_lsd;
  logic       r_dia;

  logic       w_inc_borda, w_dec_borda;
  logic       w_max;
  logic [1:0] w_inc_msd, w_dec_msd;
  logic [3:0] w_inc_lsd, w_dec_lsd;

  maq_h_detector_borda u_borda_inc (
    .clk     (maq_h_clock),
    .rst_n   (maq_h_reset),
    .i_sinal (maq_h_botao_inc),
    .o_borda (w_inc_borda)
  );

  maq_h_detector_borda u_borda_dec (
    .clk     (maq_h_clock),
    .rst_n   (maq_h_reset),
    .i_sinal (maq_h_botao_dec),
    .o_borda (w_dec_borda)
  );

  assign w_max = (r_msd == HORA_MSD_MAX) && (r_lsd == HORA_LSD_MAX_23);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_inc_msd = r_msd;
    w_inc_lsd = r_lsd + 4'd1;
    w_dec_msd = r_msd;
    w_dec_lsd = r_lsd - 4'd1;
    if (w_max) begin
      w_inc_msd = 2'd0;
      w_inc_lsd = 4'd0;
    end else if (r_lsd == LSD_MAX) begin
      w_inc_msd = r_msd + 2'd1;
      w_inc_lsd = 4'd0;
    end
    if (r_lsd == 4'd0) begin
      if (r_msd == 2'd0) begin
        w_dec_msd = HORA_MSD_MAX;
        w_dec_lsd = HORA_LSD_MAX_23;
      end else begin
        w_dec_msd = r_msd - 2'd1;
        w_dec_lsd = LSD_MAX;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge maq_h_clock) begin
    if (!maq_h_reset) begin
      r_estado <= NORMAL;
      r_msd    <= 2'd0;
      r_lsd    <= 4'd0;
      r_dia    <= 1'b0;
    end else begin
      r_estado <= maq_h_ajuste ? AJUSTE : NORMAL;
      if (r_estado == NORMAL) begin
        if (maq_h_ajuste) begin
          r_dia <= 1'b0;
        end else if (maq_h_enable1hz) begin
          r_dia <= maq_h_incremento_hora && w_max;
          if (maq_h_incremento_hora) begin
            r_msd <= w_inc_msd;
            r_lsd <= w_inc_lsd;
          end
        end
      end else begin
        // Set mode: opposing edges in the same cycle cancel out.
        r_dia <= 1'b0;
        if (w_inc_borda && !w_dec_borda) begin
          r_msd <= w_inc_msd;
          r_lsd <= w_inc_lsd;
        end else if (w_dec_borda && !w_inc_borda) begin
          r_msd <= w_dec_msd;
          r_lsd <= w_dec_lsd;
        end
      end
    end
  end

  assign maq_h_bcd_h_msd      = r_msd;
  assign maq_h_bcd_h_lsd      = r_lsd;
  assign maq_h_incremento_dia = r_dia;

`ifdef MAQ_H_FORMATO_12H_EN
  logic [4:0] w_bin, w_h12;

  always_comb begin
    w_bin    = bcd_para_bin(r_msd, r_lsd);
    w_h12    = w_bin;
    maq_h_pm = 1'b0;
    if (w_bin == 5'd0) begin
      w_h12 = 5'd12;
    end else if (w_bin >= 5'd12) begin
      maq_h_pm = 1'b1;
      if (w_bin > 5'd12) w_h12 = w_bin - 5'd12;
    end
    maq_h_disp_msd = (w_h12 >= 5'd10) ? 2'd1 : 2'd0;
    maq_h_disp_lsd = (w_h12 >= 5'd10) ? 4'(w_h12 - 5'd10) : w_h12[3:0];
  end
`else
  assign maq_h_disp_msd = r_msd;
  assign maq_h_disp_lsd = r_lsd;
  assign maq_h_pm       = 1'b0;
`endif

endmodule

// File: tb/tb_maq_h.sv
// Directed self-checking bench for the maq_h hours stage.
`timescale 1ns/1ps
module tb_maq_h;

  logic       clk = 1'b0;
  logic       rst_n, en, carry, ajuste, b_inc, b_dec;
  logic [3:0] bcd_lsd, disp_lsd;
  logic [1:0] bcd_msd, disp_msd;
  logic       pm, dia;

  int total = 0;
  int bad   = 0;

  maq_h dut (
    .maq_h_clock           (clk),
    .maq_h_reset           (rst_n),
    .maq_h_enable1hz       (en),
    .maq_h_incremento_hora (carry),
    .maq_h_ajuste          (ajuste),
    .maq_h_botao_inc       (b_inc),
    .maq_h_botao_dec       (b_dec),
    .maq_h_bcd_h_lsd       (bcd_lsd),
    .maq_h_bcd_h_msd       (bcd_msd),
    .maq_h_disp_lsd        (disp_lsd),
    .maq_h_disp_msd        (disp_msd),
    .maq_h_pm              (pm),
    .maq_h_incremento_dia  (dia)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmp_count(input string name, input logic [5:0] exp);
    total++;
    if ({bcd_msd, bcd_lsd} !== exp) begin
      bad++;
      $display("FAIL %s: count got %h want %h", name, {bcd_msd, bcd_lsd}, exp);
    end
  endtask

  task automatic cmp_dia(input string name, input logic exp);
    total++;
    if (dia !== exp) begin
      bad++;
      $display("FAIL %s: incremento_dia got %b want %b", name, dia, exp);
    end
  endtask

  task automatic pulse(input bit inc, input bit dec);
    b_inc = inc;
    b_dec = dec;
    tick();
    b_inc = 1'b0;
    b_dec = 1'b0;
    tick();
  endtask

  task automatic enable_pulse();
    en = 1'b1;
    tick();
    en = 1'b0;
    tick(3);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    en = 0; carry = 0; ajuste = 0; b_inc = 0; b_dec = 0;
    do_reset();
    cmp_count("reset_count", 6'h00);
    cmp_dia("reset_dia", 1'b0);
    total++;
`ifdef MAQ_H_FORMATO_12H_EN
    if ({disp_msd, disp_lsd, pm} !== {6'h12, 1'b0}) begin
`else
    if ({disp_msd, disp_lsd, pm} !== {6'h00, 1'b0}) begin
`endif
      bad++;
      $display("FAIL reset_disp: disp/pm got %h/%b", {disp_msd, disp_lsd}, pm);
    end
  endtask

  task automatic test_carry_wrap();
    ajuste = 1; tick();
    pulse(0, 1);
    pulse(0, 1);
    cmp_count("set_to_22", 6'h22);
    ajuste = 0; tick();
    carry = 1;
    enable_pulse();
    cmp_count("wrap_23", 6'h23);
    cmp_dia("wrap_23_dia", 1'b0);
    enable_pulse();
    cmp_count("wrap_00", 6'h00);
    cmp_dia("wrap_dia_held", 1'b1);
    carry = 0;
    enable_pulse();
    cmp_dia("wrap_dia_cleared", 1'b0);
    cmp_count("wrap_no_carry", 6'h00);
  endtask

  task automatic test_no_enable();
    carry = 1; en = 0;
    tick(1000);
    cmp_count("carry_without_enable", 6'h00);
    enable_pulse();
    cmp_count("carry_with_enable", 6'h01);
    carry = 0;
  endtask

  task automatic test_adjust();
    do_reset();
    ajuste = 1; tick();
    pulse(0, 1);
    cmp_count("adj_dec_00_23", 6'h23);
    cmp_dia("adj_dec_dia", 1'b0);
    pulse(1, 0);
    cmp_count("adj_inc_23_00", 6'h00);
    cmp_dia("adj_inc_dia", 1'b0);
    carry = 1;
    enable_pulse();
    cmp_count("adj_ignores_carry", 6'h00);
    carry = 0;
  endtask

  task automatic test_simultaneous_and_hold();
    pulse(1, 0);
    pulse(1, 0);
    pulse(1, 0);
    cmp_count("adj_to_03", 6'h03);
    pulse(1, 1);
    cmp_count("simultaneous_edges", 6'h03);
    b_inc = 1;
    tick(50);
    b_inc = 0;
    tick();
    cmp_count("inc_held_50", 6'h04);
  endtask

  task automatic test_discard_normal();
    ajuste = 0; tick();
    pulse(1, 0);
    pulse(0, 1);
    cmp_count("normal_ignores_buttons", 6'h04);
    b_inc = 1; tick(2);
    ajuste = 1; tick(3);
    b_inc = 0; tick();
    cmp_count("held_across_mode_change", 6'h04);
  endtask

  task automatic test_display_sweep();
    logic [5:0] exp_bcd [24];
    logic [5:0] exp_12  [24];
    logic       exp_pm  [24];
    exp_bcd = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09,
                6'h10, 6'h11, 6'h12, 6'h13, 6'h14, 6'h15, 6'h16, 6'h17, 6'h18, 6'h19,
                6'h20, 6'h21, 6'h22, 6'h23};
    exp_12  = '{6'h12, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09,
                6'h10, 6'h11, 6'h12, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                6'h08, 6'h09, 6'h10, 6'h11};
    exp_pm  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    do_reset();
    ajuste = 1; tick();
    for (int h = 0; h < 24; h++) begin
      cmp_count("sweep_count", exp_bcd[h]);
      total++;
`ifdef MAQ_H_FORMATO_12H_EN
      if ({disp_msd, disp_lsd} !== exp_12[h] || pm !== exp_pm[h]) begin
        bad++;
        $display("FAIL sweep_disp h=%0d: disp/pm got %h/%b want %h/%b",
                 h, {disp_msd, disp_lsd}, pm, exp_12[h], exp_pm[h]);
      end
`else
      if ({disp_msd, disp_lsd} !== exp_bcd[h] || pm !== 1'b0) begin
        bad++;
        $display("FAIL sweep_disp h=%0d: disp/pm got %h/%b want %h/0",
                 h, {disp_msd, disp_lsd}, pm, exp_bcd[h]);
      end
`endif
      pulse(1, 0);
    end
    cmp_count("sweep_wrap", 6'h00);
  endtask

  task automatic test_reset_mid_adjust();
    for (int i = 0; i < 17; i++) pulse(1, 0);
    cmp_count("adj_to_17", 6'h17);
    b_inc = 1;
    rst_n = 0;
    tick();
    cmp_count("reset_mid_adjust", 6'h00);
    cmp_dia("reset_mid_adjust_dia", 1'b0);
    rst_n = 1; b_inc = 0; ajuste = 0;
    carry = 1; en = 1;
    tick();
    en = 0; carry = 0;
    cmp_count("normal_after_reset", 6'h01);
    pulse(1, 0);
    cmp_count("buttons_ignored_after_reset", 6'h01);
  endtask

  initial begin
    test_reset();
    test_carry_wrap();
    test_no_enable();
    test_adjust();
    test_simultaneous_and_hold();
    test_discard_normal();
    test_display_sweep();
    test_reset_mid_adjust();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/maq_h.md
MAQ_H -- requirements
Module: maq_h

Interface
REQ-001 SHALL have ports: maq_h_clock  in  1  system clock; all logic on rising edge.
REQ-002 SHALL have: maq_h_reset  in  1  synchronous, active-low reset; sampled on maq_h_clock.
REQ-003 SHALL have: maq_h_enable1hz  in  1  one-clock pulse per second; time base.
REQ-004 SHALL have: maq_h_incremento_hora  in  1  hour carry from the minutes stage; a level held for one full enable period.
REQ-005 SHALL have: maq_h_ajuste  in  1  level; 1 = manual set mode.
REQ-006 SHALL have: maq_h_botao_inc  in  1  set-mode increment button, already debounced and synchronised.
REQ-007 SHALL have: maq_h_botao_dec  in  1  set-mode decrement button, already debounced and synchronised.
REQ-008 SHALL have: maq_h_bcd_h_lsd  out  4  hour units, BCD, 24 h format.
REQ-009 SHALL have: maq_h_bcd_h_msd  out  2  hour tens, BCD, 24 h format.
REQ-010 SHALL have: maq_h_disp_lsd  out  4  display hour units.
REQ-011 SHALL have: maq_h_disp_msd  out  2  display hour tens.
REQ-012 SHALL have: maq_h_pm  out  1  PM indicator.
REQ-013 SHALL have: maq_h_incremento_dia  out  1  day carry, registered.

Function
REQ-014 Counter SHALL hold hours 00..23 in BCD; lsd never exceeds 9, and never exceeds 3 while msd = 2.
REQ-015 FSM states SHALL be NORMAL and AJUSTE; NORMAL->AJUSTE when maq_h_ajuste=1; AJUSTE->NORMAL when maq_h_ajuste=0; each transition takes effect on the next clock edge.
REQ-016 In NORMAL, maq_h_incremento_hora SHALL be sampled only in cycles with maq_h_enable1hz=1; each such cycle with the carry high adds exactly one hour.
REQ-017 Increment SHALL apply these rules: lsd 9 -> 0 with msd+1; 23 -> 00.
REQ-018 maq_h_incremento_dia SHALL update only in maq_h_enable1hz cycles: set to 1 on the 23->00 wrap, otherwise cleared. It is therefore held for exactly one enable period.
REQ-019 In AJUSTE, maq_h_incremento_hora SHALL be ignored, and maq_h_incremento_dia SHALL be 0 at the next clock edge and stay 0.
REQ-020 In AJUSTE, each rising edge of botao_inc SHALL add one hour (23 -> 00) and each rising edge of botao_dec SHALL subtract one hour (00 -> 23), applied the clock after the edge, independent of enable1hz, and never raising the day carry.
REQ-021 Rising edges on inc and dec in the same cycle SHALL leave the count unchanged.
REQ-022 A button held high SHALL produce exactly one step; edges occurring while in NORMAL SHALL be discarded.
REQ-023 All outputs SHALL be registered or decoded purely from registers; no input-to-output combinational path.

Reset
REQ-024 While maq_h_reset=0 at a clock edge, the block SHALL set: count 00, FSM NORMAL, incremento_dia 0, pm 0, disp 12 (12 h build) or 00 (24 h build), edge-detector history 0.
REQ-025 Reset SHALL override every other input, including mid-adjust and mid-carry; the first clock after release behaves as a normal NORMAL-state cycle.

Configuration
REQ-026 Macro MAQ_H_FORMATO_12H_EN defined: disp SHALL show 12 h format, with 00 -> 12 and pm=0, 01..11 -> same value with pm=0, 12 -> 12 with pm=1, and 13..23 -> 01..11 with pm=1.
REQ-027 Macro undefined: disp SHALL equal bcd_h and maq_h_pm SHALL be constant 0. The port list is identical in both builds, and the internal counter is always 24 h.

Structure
REQ-028 Shared package maq_relogio_pkg SHALL hold the FSM state enum and the BCD limit constants (HORA_MSD_MAX=2, HORA_LSD_MAX_23=3, LSD_MAX=9).
REQ-029 Rising-edge detection SHALL be one sub-module, maq_h_detector_borda, instantiated once per button.

Verification
REQ-030 Release reset at 22, hold carry=1 for two enable pulses -> count 23 then 00, incremento_dia=1 for one enable period, then 0.
REQ-031 Carry=1 with enable1hz=0 for 1000 clocks -> count unchanged.
REQ-032 Ajuste=1, count 00, one dec pulse -> 23; one inc pulse -> 00; incremento_dia stays 0.
REQ-033 Ajuste=1, simultaneous inc and dec edges -> count unchanged; inc held high 50 clocks -> exactly +1.
REQ-034 12 h build: sweep 00..23 -> disp/pm read 12/0, 01/0 .. 11/0, 12/1, 01/1 .. 11/1.
REQ-035 Reset asserted mid-ajuste at count 17 -> next clock shows count 00, state NORMAL, incremento_dia 0.
